// File: rtl/memory_access_stage_if.sv
// Data-bus interface between the memory access stage (master) and memory (slave).
// One access at a time: req held with addr/we/be/wdata stable until ack is sampled.
interface memory_access_stage_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, be, addr, wdata, input rdata, ack);
  modport slave  (input req, we, be, addr, wdata, output rdata, ack);
endinterface

// File: rtl/memory_access_stage.sv
// Memory access pipeline stage: captures execute results, performs up to two
// data-bus accesses (slot 1 then slot 2), then pulses write-back data/tags.
// stall is high while the stage is busy (any state other than IDLE).
// Optional feature: define MEM_ALIGN_CHECK_EN to fault misaligned LW/LH/LHU/SH
// instead of silently dropping the low address bits.
module memory_access_stage #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] r1,
  input  logic [31:0] r2,
  input  logic        cres,
  input  logic [31:0] m_a1,
  input  logic [31:0] m_a2,
  input  logic [3:0]  m_r1_op,
  input  logic [3:0]  m_r2_op,
  input  logic [4:0]  r_a1,
  input  logic [4:0]  r_a2,
  input  logic [3:0]  r_op,
  memory_access_stage_if.master bus,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_d1,
  output logic [31:0] wb_d2,
  output logic [4:0]  wb_a1,
  output logic [4:0]  wb_a2,
  output logic [3:0]  wb_op,
  output logic        fault
);

  localparam logic [3:0] OP_LW  = 4'b0001;
  localparam logic [3:0] OP_LHU = 4'b0010;
  localparam logic [3:0] OP_LH  = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LB  = 4'b0101;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_SH  = 4'b1010;
  localparam logic [3:0] OP_SB  = 4'b1100;

  // Counter only needs to reach TIMEOUT_CYC-1 before the access is abandoned.
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, OUT} state_t;

  function automatic logic is_ld(input logic [3:0] op);
    return op inside {OP_LW, OP_LHU, OP_LH, OP_LBU, OP_LB};
  endfunction

  function automatic logic is_mem(input logic [3:0] op);
    return is_ld(op) || (op inside {OP_SW, OP_SH, OP_SB});
  endfunction

  state_t st, st_nxt;

  // captured slot
  logic [31:0] c_r1, c_r2, c_a1, c_a2;
  logic [3:0]  c_op1, c_op2, c_rop;
  logic [4:0]  c_ra1, c_ra2;
  logic        c_cancel;
  logic [31:0] d1, d2;
  logic        flt;
  logic [CNT_W-1:0] cnt;

  // current access (slot selected by state)
  logic        sel2;
  logic [3:0]  cur_op;
  logic [31:0] cur_a, cur_r;
  logic        cur_mis;
  logic        in_acc, tmo, ack_ok, abort;
  logic [3:0]  lane_be;
  logic [31:0] lane_wd, ld_val;
  logic [15:0] hw;
  logic [7:0]  bt;

  assign stall = (st != IDLE);

  // Select the slot being accessed; ACC2 always means slot 2.
  always_comb begin
    in_acc = (st == ACC1) || (st == ACC2);
    sel2   = (st == ACC2);
    cur_op = sel2 ? c_op2 : c_op1;
    cur_a  = sel2 ? c_a2  : c_a1;
    cur_r  = sel2 ? c_r2  : c_r1;
  end

  // Misaligned access detection (optional); a misaligned slot never raises req.
  always_comb begin
`ifdef MEM_ALIGN_CHECK_EN
    cur_mis = ((cur_op == OP_LW) && (cur_a[1:0] != 2'b00)) ||
              ((cur_op inside {OP_LH, OP_LHU, OP_SH}) && cur_a[0]);
`else
    cur_mis = 1'b0;
`endif
  end

  // Byte-lane enables, replicated store data and extended load data.
  always_comb begin
    lane_be = 4'b0000;
    lane_wd = cur_r;
    hw      = cur_a[1] ? bus.rdata[31:16] : bus.rdata[15:0];
    bt      = bus.rdata[{cur_a[1:0], 3'b000} +: 8];
    ld_val  = bus.rdata;
    case (cur_op)
      OP_LW, OP_SW:          lane_be = 4'b1111;
      OP_LHU, OP_LH, OP_SH:  lane_be = cur_a[1] ? 4'b1100 : 4'b0011;
      OP_LBU, OP_LB, OP_SB:  lane_be = 4'b0001 << cur_a[1:0];
      default:               lane_be = 4'b0000;
    endcase
    case (cur_op)
      OP_SH:   lane_wd = {2{cur_r[15:0]}};
      OP_SB:   lane_wd = {4{cur_r[7:0]}};
      default: lane_wd = cur_r;
    endcase
    case (cur_op)
      OP_LHU:  ld_val = {16'h0000, hw};
      OP_LH:   ld_val = {{16{hw[15]}}, hw};
      OP_LBU:  ld_val = {24'h000000, bt};
      OP_LB:   ld_val = {{24{bt[7]}}, bt};
      default: ld_val = bus.rdata;
    endcase
  end

  // Bus drive: quiet (all zero) outside an active, aligned access.
  always_comb begin
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.be    = 4'b0000;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    if (in_acc && !cur_mis) begin
      bus.req   = 1'b1;
      bus.we    = cur_op[3];
      bus.be    = lane_be;
      bus.addr  = {cur_a[31:2], 2'b00};
      bus.wdata = lane_wd;
    end
  end

  // Access completion / abort; an ack in the same cycle as the timeout wins.
  always_comb begin
    tmo    = (TIMEOUT_CYC > 0) && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    ack_ok = in_acc && !cur_mis && bus.ack;
    abort  = in_acc && (cur_mis || (!bus.ack && tmo));
  end

  // Next-state logic.
  always_comb begin
    st_nxt = st;
    case (st)
      IDLE: if (in_valid) begin
        if (!cres)                st_nxt = OUT;
        else if (is_mem(m_r1_op)) st_nxt = ACC1;
        else if (is_mem(m_r2_op)) st_nxt = ACC2;
        else                      st_nxt = OUT;
      end
      ACC1: begin
        if (abort)       st_nxt = OUT;
        else if (ack_ok) st_nxt = is_mem(c_op2) ? ACC2 : OUT;
      end
      ACC2: if (abort || ack_ok) st_nxt = OUT;
      OUT:  st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  // Capture, access bookkeeping and write-back outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_r1 <= '0; c_r2 <= '0; c_a1 <= '0; c_a2 <= '0;
      c_op1 <= '0; c_op2 <= '0; c_rop <= '0;
      c_ra1 <= '0; c_ra2 <= '0; c_cancel <= 1'b0;
      d1 <= '0; d2 <= '0; flt <= 1'b0; cnt <= '0;
      wb_valid <= 1'b0; fault <= 1'b0;
      wb_d1 <= '0; wb_d2 <= '0; wb_a1 <= '0; wb_a2 <= '0; wb_op <= '0;
    end else begin
      wb_valid <= 1'b0;
      fault    <= 1'b0;
      // timeout counter restarts on every state change (entry to ACC1/ACC2)
      if (st != st_nxt) cnt <= '0;
      else if (in_acc)  cnt <= cnt + 1'b1;
      case (st)
        IDLE: if (in_valid) begin
          c_r1 <= r1;       c_r2 <= r2;
          c_a1 <= m_a1;     c_a2 <= m_a2;
          c_op1 <= m_r1_op; c_op2 <= m_r2_op;
          c_ra1 <= r_a1;    c_ra2 <= r_a2;   c_rop <= r_op;
          c_cancel <= !cres;
          d1 <= r1; d2 <= r2;
          flt <= 1'b0;
        end
        ACC1, ACC2: begin
          if (abort) flt <= 1'b1;
          else if (ack_ok && is_ld(cur_op)) begin
            if (sel2) d2 <= ld_val;
            else      d1 <= ld_val;
          end
        end
        OUT: begin
          wb_valid <= 1'b1;
          fault    <= flt;
          wb_d1    <= d1;
          wb_d2    <= d2;
          wb_a1    <= c_ra1;
          wb_a2    <= c_ra2;
          wb_op    <= (c_cancel || flt) ? 4'b0000 : c_rop;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: a transaction-level model predicts
// bus accesses and write-back results; a bus responder and a write-back
// monitor pop and compare independently of the stimulus process.
module tb_memory_access_stage;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, cres;
  logic [31:0] r1, r2, m_a1, m_a2;
  logic [3:0]  m_r1_op, m_r2_op, r_op;
  logic [4:0]  r_a1, r_a2;
  logic        stall, wb_valid, fault;
  logic [31:0] wb_d1, wb_d2;
  logic [4:0]  wb_a1, wb_a2;
  logic [3:0]  wb_op;

  memory_access_stage_if bus();

  memory_access_stage #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .r1(r1), .r2(r2), .cres(cres),
    .m_a1(m_a1), .m_a2(m_a2), .m_r1_op(m_r1_op), .m_r2_op(m_r2_op),
    .r_a1(r_a1), .r_a2(r_a2), .r_op(r_op), .bus(bus),
    .stall(stall), .wb_valid(wb_valid), .wb_d1(wb_d1), .wb_d2(wb_d2),
    .wb_a1(wb_a1), .wb_a2(wb_a2), .wb_op(wb_op), .fault(fault)
  );

  typedef struct {
    logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata;
    int dly; logic [31:0] rdata;
  } acc_t;
  typedef struct {
    logic [31:0] d1, d2; logic [4:0] a1, a2; logic [3:0] op; logic fault;
  } wb_t;
  typedef struct {
    logic cres; logic [31:0] r1, r2, a1, a2; logic [3:0] op1, op2, rop;
    logic [4:0] ra1, ra2; int dly1, dly2; logic [31:0] rd1, rd2;
  } txn_t;

  acc_t acc_q[$];
  wb_t  wb_q[$];
  int   total = 0;
  int   bad = 0;
  logic resp_en;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction-level model: queues expected bus accesses and write-back,
  // returns the expected number of stalled cycles after capture.
  function automatic int model(input txn_t t);
    logic [31:0] d [2];
    logic [31:0] a, r, rd, v;
    logic [3:0]  op;
    int dly, cyc, off;
    bit flt;
    acc_t e;
    wb_t  w;
    flt = 0; cyc = 1;
    d[0] = t.r1; d[1] = t.r2;
    if (t.cres) begin
      for (int s = 0; s < 2; s++) begin
        if (flt) break;
        op  = (s == 1) ? t.op2  : t.op1;
        a   = (s == 1) ? t.a2   : t.a1;
        r   = (s == 1) ? t.r2   : t.r1;
        dly = (s == 1) ? t.dly2 : t.dly1;
        rd  = (s == 1) ? t.rd2  : t.rd1;
        if (!(op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd12})) continue;
`ifdef MEM_ALIGN_CHECK_EN
        if ((op == 4'd1 && a % 4 != 0) ||
            ((op == 4'd2 || op == 4'd3 || op == 4'd10) && a % 2 != 0)) begin
          flt = 1; cyc += 1; break;
        end
`endif
        e.addr = a - (a % 4);
        e.we   = (op >= 4'd8);
        case (op)
          4'd1, 4'd9:         e.be = 4'hF;
          4'd2, 4'd3, 4'd10:  e.be = 4'(3 << (2 * ((a / 2) % 2)));
          default:            e.be = 4'(1 << (a % 4));
        endcase
        if (op == 4'd10)      e.wdata = (r % 65536) * 32'h00010001;
        else if (op == 4'd12) e.wdata = (r % 256) * 32'h01010101;
        else                  e.wdata = r;
        e.dly = dly; e.rdata = rd;
        acc_q.push_back(e);
        if (dly >= TMO) begin flt = 1; cyc += TMO; break; end
        cyc += dly + 1;
        case (op)
          4'd1: d[s] = rd;
          4'd2, 4'd3: begin
            off = ((a / 2) % 2) * 16;
            v = (rd >> off) % 65536;
            d[s] = (op == 4'd3 && v >= 32768) ? v - 65536 : v;
          end
          4'd4, 4'd5: begin
            off = (a % 4) * 8;
            v = (rd >> off) % 256;
            d[s] = (op == 4'd5 && v >= 128) ? v - 256 : v;
          end
          default: ;
        endcase
      end
    end
    w.d1 = d[0]; w.d2 = d[1]; w.a1 = t.ra1; w.a2 = t.ra2;
    w.op = (t.cres && !flt) ? t.rop : 4'd0;
    w.fault = flt;
    wb_q.push_back(w);
    return cyc;
  endfunction

  // Issue one transaction at #1 after an edge with the stage idle.
  task automatic run_txn(input txn_t t);
    int exp_cyc, n;
    exp_cyc = model(t);
    cres = t.cres; r1 = t.r1; r2 = t.r2; m_a1 = t.a1; m_a2 = t.a2;
    m_r1_op = t.op1; m_r2_op = t.op2; r_a1 = t.ra1; r_a2 = t.ra2; r_op = t.rop;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (stall && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    chk("stall_cycles", n, exp_cyc);
    if (n < 200) chk("wb_valid_when_released", wb_valid, 1'b1);
  endtask

  function automatic txn_t rnd_txn();
    txn_t t;
    t.cres = ($urandom_range(0, 7) != 0);
    t.r1 = $urandom; t.r2 = $urandom; t.a1 = $urandom; t.a2 = $urandom;
    t.op1 = 4'($urandom_range(0, 15)); t.op2 = 4'($urandom_range(0, 15));
    t.rop = 4'($urandom_range(1, 15));
    t.ra1 = 5'($urandom_range(0, 31)); t.ra2 = 5'($urandom_range(0, 31));
    t.dly1 = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, 5));
    t.dly2 = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, 5));
    t.rd1 = $urandom; t.rd2 = $urandom;
    return t;
  endfunction

  // Bus responder: pops the predicted access on each new request, checks it,
  // acks after the predicted delay (or never, to force a timeout).
  bit   rs_busy = 0;
  int   rs_wait = 0;
  int   rs_len  = 0;
  acc_t rs_e;
  initial begin
    bus.ack = 1'b0; bus.rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!resp_en) begin rs_busy = 0; continue; end
      bus.ack = 1'b0;
      bus.rdata = $urandom;
      if (!bus.req) begin
        if (rs_busy) chk("req_len_on_timeout", rs_len, TMO);
        rs_busy = 0;
      end else begin
        if (!rs_busy) begin
          if (acc_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_req: got addr %h expected no request", bus.addr);
            rs_e.dly = 1000; rs_e.rdata = 32'h0;
          end else begin
            rs_e = acc_q.pop_front();
            chk("bus_addr", bus.addr, rs_e.addr);
            chk("bus_we", bus.we, rs_e.we);
            chk("bus_be", bus.be, rs_e.be);
            chk("bus_wdata", bus.wdata, rs_e.wdata);
          end
          rs_busy = 1; rs_wait = rs_e.dly; rs_len = 0;
        end
        rs_len++;
        if (rs_wait == 0) begin
          bus.ack = 1'b1; bus.rdata = rs_e.rdata; rs_busy = 0;
        end else rs_wait--;
      end
    end
  end

  // Write-back monitor.
  wb_t mw;
  always @(negedge clk) begin
    if (wb_valid) begin
      if (wb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_wb: got wb_valid=1 expected 0");
      end else begin
        mw = wb_q.pop_front();
        chk("wb_d1", wb_d1, mw.d1);
        chk("wb_d2", wb_d2, mw.d2);
        chk("wb_a1", wb_a1, mw.a1);
        chk("wb_a2", wb_a2, mw.a2);
        chk("wb_op", wb_op, mw.op);
        chk("wb_fault", fault, mw.fault);
      end
    end else if (!rst) begin
      chk("fault_outside_wb", fault, 1'b0);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  txn_t t;
  initial begin
    rst = 1'b1; in_valid = 1'b0; cres = 1'b0; r1 = '0; r2 = '0; m_a1 = '0; m_a2 = '0;
    m_r1_op = '0; m_r2_op = '0; r_a1 = '0; r_a2 = '0; r_op = '0; resp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_req", bus.req, 1'b0);
    chk("rst_we", bus.we, 1'b0);
    chk("rst_be", bus.be, 4'h0);
    chk("rst_addr", bus.addr, 32'h0);
    chk("rst_wdata", bus.wdata, 32'h0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_wb_d1", wb_d1, 32'h0);
    chk("rst_wb_d2", wb_d2, 32'h0);
    chk("rst_wb_a", {wb_a1, wb_a2}, 10'h0);
    chk("rst_wb_op", wb_op, 4'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // no memory ops: pass-through
    t = '{default: 0};
    t.cres = 1; t.r1 = 5; t.r2 = 7; t.rop = 3; t.ra1 = 1; t.ra2 = 2;
    run_txn(t);
    // LB at byte 3, sign extended, ack after 3 wait cycles
    t = '{default: 0};
    t.cres = 1; t.op1 = 4'd5; t.a1 = 32'h103; t.dly1 = 3; t.rd1 = 32'h80000000; t.rop = 4;
    run_txn(t);
    // SH then LHU
    t = '{default: 0};
    t.cres = 1; t.op1 = 4'd10; t.a1 = 32'h202; t.r1 = 32'h1234;
    t.op2 = 4'd2; t.a2 = 32'h204; t.rd2 = 32'h0000BEEF; t.dly2 = 1; t.rop = 5;
    run_txn(t);
    // cancelled store
    t = '{default: 0};
    t.cres = 0; t.op1 = 4'd9; t.a1 = 32'h300; t.r1 = 32'hCAFE0001; t.rop = 6;
    run_txn(t);
    // timeout on slot 1 skips slot 2
    t = '{default: 0};
    t.cres = 1; t.op1 = 4'd1; t.a1 = 32'h400; t.dly1 = 100;
    t.op2 = 4'd9; t.a2 = 32'h404; t.rop = 7;
    run_txn(t);
    // ack exactly on the last allowed cycle
    t = '{default: 0};
    t.cres = 1; t.op2 = 4'd1; t.a2 = 32'h500; t.dly2 = TMO - 1; t.rd2 = 32'h13572468; t.rop = 8;
    run_txn(t);
    // misaligned word load (faults only with alignment checking)
    t = '{default: 0};
    t.cres = 1; t.op1 = 4'd1; t.a1 = 32'h2; t.rd1 = 32'hA5A5A5A5; t.rop = 9;
    run_txn(t);

    // reset in the middle of an access; late ack must be ignored
    resp_en = 1'b0;
    cres = 1'b1; m_r1_op = 4'd1; m_a1 = 32'h40; m_r2_op = 4'd0; r_op = 4'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_mid_req_before", bus.req, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_req_dropped", bus.req, 1'b0);
    chk("rst_mid_stall", stall, 1'b0);
    bus.ack = 1'b1; bus.rdata = 32'hDEADBEEF; rst = 1'b0;
    @(posedge clk); #1;
    bus.ack = 1'b0;
    chk("rst_mid_no_wb", wb_valid, 1'b0);
    chk("rst_mid_idle", stall, 1'b0);
    chk("rst_mid_wb_op", wb_op, 4'h0);
    repeat (2) begin @(posedge clk); #1; end
    resp_en = 1'b1;

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      run_txn(rnd_txn());
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (4) begin @(posedge clk); #1; end
    chk("wb_queue_drained", wb_q.size(), 0);
    chk("acc_queue_drained", acc_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
